// File: rtl/audio_mux_mc.sv
// audio_mux_mc: register-mapped multi-channel audio sample mux for the host
// reader. It adds a coherent-frame snapshot mode, a buffer-fill state machine
// with underrun counting, and trig/i2s_enable generation for the sample pacer.
module audio_mux_mc #(
    parameter int NUM_CH        = 2,
    parameter int AUD_BIT_DEPTH = 24,
    parameter int FIFO_WIDTH    = 6,
    parameter int ADDR_W        = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDR_W-1:0]               address,
    input  logic                            read,
    input  logic                            write,
    input  logic [31:0]                     datain,
    input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] sound_in,
    input  logic                            xxxx_top,
    input  logic                            lrck,
    input  logic                            run,
    output logic [31:0]                     dataout,
    output logic [NUM_CH-1:0]               ch_read,
    output logic                            trig,
    output logic                            i2s_enable,
    output logic                            fill_busy
);

    localparam int CW = FIFO_WIDTH + 1;
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] A_BUFSIZE  = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(14);
    localparam logic [ADDR_W-1:0] A_UNDERRUN = ADDR_W'(15);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_counter;
    logic [CW-1:0]            w_counter_nxt;
    logic [CW-1:0]            r_bufsize;
    logic [15:0]              r_underrun;
    logic [15:0]              w_underrun_nxt;
    logic                     r_jack_read_act;
    logic                     r_jack_act_d;
    logic                     r_snap_en;
    logic                     r_run_trig;
    logic [31:0]              r_dataout;
    logic [AUD_BIT_DEPTH-1:0] r_shadow [NUM_CH];

    logic                     w_wr_ctrl;
    logic                     w_wr_bufsize;
    logic                     w_wr_underrun;
    logic                     w_is_chan;
    logic                     w_snap_latch;
    logic                     w_jack_cycle_end;
    logic                     w_pulse;
    logic [AUD_BIT_DEPTH-1:0] w_live;
    logic [AUD_BIT_DEPTH-1:0] w_shadow;
    logic [31:0]              w_status;
    logic [31:0]              w_rdata;
    logic                     w_unused;

    // Only a handful of write-data bits are architecturally meaningful.
    assign w_unused = ^datain;

    assign w_wr_ctrl        = write && (address == A_CTRL);
    assign w_wr_bufsize     = write && (address == A_BUFSIZE);
    assign w_wr_underrun    = write && (address == A_UNDERRUN);
    assign w_is_chan        = (32'(address) < 32'(NUM_CH));
    assign w_snap_latch     = read && r_snap_en && (address == '0);
    assign w_jack_cycle_end = r_jack_act_d && !r_jack_read_act;

    // A fill pulse needs room in the buffer. A buffer-size write or the end of
    // a host read cycle restarts the count, so no pulse fires on those edges.
    assign w_pulse = (r_state == ST_FILL) && xxxx_top && !run &&
                     (r_counter < r_bufsize) &&
                     !w_jack_cycle_end && !w_wr_bufsize;

    assign trig       = (r_state == ST_IDLE) ? lrck : r_run_trig;
    assign i2s_enable = (r_state == ST_IDLE);
    assign fill_busy  = (r_state == ST_FILL);
    assign dataout    = r_dataout;

    // Per-channel read strobes go straight to the synth, decoded in the same cycle.
    always_comb begin
        ch_read = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_read[k] = read && (address == ADDR_W'(k));
        end
    end

    // Select the live and shadow sample for the addressed channel.
    always_comb begin
        w_live   = '0;
        w_shadow = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (address == ADDR_W'(k)) begin
                w_live   = sound_in[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH];
                w_shadow = r_shadow[k];
            end
        end
    end

    // Pack the status word: fill counter, FSM state and host-read flag.
    always_comb begin
        w_status                 = '0;
        w_status[FIFO_WIDTH:0]   = r_counter;
        w_status[17:16]          = r_state;
        w_status[24]             = r_jack_read_act;
    end

    // Read-data mux. Samples are MSB-aligned; in snapshot mode channel 0 is
    // live and every other channel comes from the frame latched with it.
    always_comb begin
        w_rdata = '0;
        if (w_is_chan) begin
            if (r_snap_en && (address != '0)) begin
                w_rdata = 32'(w_shadow) << (32 - AUD_BIT_DEPTH);
            end else begin
                w_rdata = 32'(w_live) << (32 - AUD_BIT_DEPTH);
            end
        end else begin
            case (address)
                A_STATUS:   w_rdata = w_status;
                A_UNDERRUN: w_rdata = {16'h0000, r_underrun};
                default:    w_rdata = '0;
            endcase
        end
    end

    // Fill FSM next-state logic; a buffer-size write overrides everything else.
    always_comb begin
        w_state_nxt    = r_state;
        w_counter_nxt  = r_counter;
        w_underrun_nxt = r_underrun;
        if (w_wr_bufsize) begin
            w_counter_nxt = '0;
            w_state_nxt   = (datain[FIFO_WIDTH:0] == '0) ? ST_IDLE : ST_FILL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_FILL: begin
                    if (w_jack_cycle_end) begin
                        w_counter_nxt = '0;
                        if (r_underrun != 16'hFFFF) begin
                            w_underrun_nxt = r_underrun + 16'd1;
                        end
                    end else if (w_pulse) begin
                        w_counter_nxt = r_counter + CW'(1);
                        if ((r_counter + CW'(1)) == r_bufsize) begin
                            w_state_nxt = ST_WAIT_END;
                        end
                    end
                end
                ST_WAIT_END: begin
                    if (w_jack_cycle_end) begin
                        w_state_nxt   = ST_FILL;
                        w_counter_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        if (w_wr_underrun) begin
            w_underrun_nxt = '0;
        end
    end

    // Fill FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control registers, fill counter, underrun count and the trigger pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter       <= '0;
            r_bufsize       <= '0;
            r_underrun      <= '0;
            r_jack_read_act <= 1'b0;
            r_jack_act_d    <= 1'b0;
            r_snap_en       <= 1'b0;
            r_run_trig      <= 1'b0;
        end else begin
            r_counter    <= w_counter_nxt;
            r_underrun   <= w_underrun_nxt;
            r_jack_act_d <= r_jack_read_act;
            r_run_trig   <= w_pulse;
            if (w_wr_bufsize) begin
                r_bufsize <= datain[FIFO_WIDTH:0];
            end
            if (w_wr_ctrl) begin
                r_jack_read_act <= datain[0];
                r_snap_en       <= datain[1];
            end
        end
    end

    // Registered read data; it holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dataout <= '0;
        end else if (read) begin
            r_dataout <= w_rdata;
        end
    end

    // Snapshot every channel on the same edge that channel 0 is read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_snap_latch) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= sound_in[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH];
            end
        end
    end

endmodule
